// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC controller.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] EXC_VEC_DEF  = 32'h0000_0380;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // Larger value wins when sources compete for the next PC.
    typedef enum logic [2:0] {
        PRIO_SEQ    = 3'd0,
        PRIO_PEND   = 3'd1,
        PRIO_BRANCH = 3'd2,
        PRIO_JUMP   = 3'd3,
        PRIO_EXC    = 3'd4
    } redir_prio_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority selector for the next fetch address: exc > jump > branch > pending > pc+4.
module pc_next_mux
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic            exc,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            pend_valid,
    input  logic [XLEN-1:0] pend_target,
    input  logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc_c
);

    redir_prio_e     sel;
    logic [XLEN-1:0] raw_pc;

    always_comb begin
        sel    = PRIO_SEQ;
        raw_pc = pc_plus4;
        if (exc) begin
            sel = PRIO_EXC;
        end else if (jump) begin
            sel = PRIO_JUMP;
        end else if (branch_taken) begin
            sel = PRIO_BRANCH;
        end else if (pend_valid) begin
            sel = PRIO_PEND;
        end
        case (sel)
            PRIO_EXC:    raw_pc = EXC_VEC;
            PRIO_JUMP:   raw_pc = jump_target;
            PRIO_BRANCH: raw_pc = branch_target;
            PRIO_PEND:   raw_pc = pend_target;
            default:     raw_pc = pc_plus4;
        endcase
        next_pc_c = align_word(raw_pc);
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: owns the PC, drives inst_ce and handles waits, stalls, redirects and exceptions.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            exc,
    input  logic            inst_ready,
    output logic            inst_ce,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_plus4
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    redir_prio_e     pend_prio_q, pend_prio_d;

    logic [XLEN-1:0] next_pc_c;
    logic            redir_req_c;
    redir_prio_e     redir_prio_c;
    logic [XLEN-1:0] redir_target_c;

    assign pc_plus4       = pc_q + XLEN'(4);
    assign redir_req_c    = jump | branch_taken;
    assign redir_prio_c   = jump ? PRIO_JUMP : PRIO_BRANCH;
    assign redir_target_c = align_word(jump ? jump_target : branch_target);

    pc_next_mux #(
        .EXC_VEC (EXC_VEC)
    ) u_pc_next_mux (
        .exc           (exc),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pend_valid    (pend_valid_q),
        .pend_target   (pend_target_q),
        .pc_plus4      (pc_plus4),
        .next_pc_c     (next_pc_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            pend_prio_q   <= PRIO_SEQ;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_prio_q   <= pend_prio_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_prio_d   = pend_prio_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (inst_ready) begin
                    pc_d         = next_pc_c;
                    pend_valid_d = 1'b0;
                    state_d      = stall ? ST_HOLD : ST_FETCH;
                end else if (redir_req_c &&
                             (!pend_valid_q || redir_prio_c >= pend_prio_q)) begin
                    // Redirect targets the fetch after the one still in flight.
                    pend_valid_d  = 1'b1;
                    pend_target_d = redir_target_c;
                    pend_prio_d   = redir_prio_c;
                end
            end
            ST_HOLD: begin
                if (redir_req_c) begin
                    pc_d = next_pc_c;
                end
                if (!stall) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Exception flushes everything and restarts fetch at the vector.
        if (exc) begin
            pc_d         = next_pc_c;
            pend_valid_d = 1'b0;
            state_d      = ST_FETCH;
        end
    end

    assign inst_ce  = (state_q == ST_FETCH);
    assign pc_valid = (state_q == ST_FETCH) & inst_ready & ~exc;
    assign pc       = pc_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with a behavioural reference model checked every cycle.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] EXC_ADDR = 32'h0000_0380;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc;
    logic        inst_ready;
    logic        inst_ce;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] pc_plus4;

    int total = 0;
    int bad   = 0;

    fetch_pc_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exc           (exc),
        .inst_ready    (inst_ready),
        .inst_ce       (inst_ce),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .pc_plus4      (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: has fetching started, is it parked by a stall, and one remembered redirect.
    bit          m_started  = 1'b0;
    bit          m_held     = 1'b0;
    logic [31:0] m_pc       = 32'h0;
    bit          m_pend_v   = 1'b0;
    logic [31:0] m_pend     = 32'h0;
    int          m_pend_rank = 0;

    function automatic logic [31:0] aligned(input logic [31:0] a);
        logic [31:0] r;
        r = a & 32'hFFFF_FFFC;
        return r;
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_held    = 1'b0;
        m_pc      = 32'h0;
        m_pend_v  = 1'b0;
    endtask

    task automatic model_step();
        int rank;
        if (exc) begin
            m_started = 1'b1;
            m_held    = 1'b0;
            m_pc      = EXC_ADDR;
            m_pend_v  = 1'b0;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (!m_held) begin
            if (inst_ready) begin
                if (jump)              m_pc = aligned(jump_target);
                else if (branch_taken) m_pc = aligned(branch_target);
                else if (m_pend_v)     m_pc = m_pend;
                else                   m_pc = m_pc + 32'd4;
                m_pend_v = 1'b0;
                m_held   = stall;
            end else if (jump || branch_taken) begin
                rank = jump ? 2 : 1;
                if (!m_pend_v || rank >= m_pend_rank) begin
                    m_pend_v    = 1'b1;
                    m_pend      = aligned(jump ? jump_target : branch_target);
                    m_pend_rank = rank;
                end
            end
        end else begin
            if (jump)              m_pc = aligned(jump_target);
            else if (branch_taken) m_pc = aligned(branch_target);
            if (!stall) m_held = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        if (rst) model_step();
    end

    // Compare every cycle, mid-way between the input update and the next rising edge.
    always @(negedge clk) begin
        logic exp_ce;
        #3;
        if (!rst) model_reset();
        exp_ce = m_started && !m_held;
        chk_bit("m_inst_ce", inst_ce, exp_ce);
        chk_bit("m_pc_valid", pc_valid, exp_ce && inst_ready && !exc);
        chk("m_pc", pc, m_pc);
        chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
    end

    task automatic clear_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        exc           = 1'b0;
        inst_ready    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);

        // Back-to-back fetch from reset
        do_reset();
        inst_ready = 1'b1;
        #4 chk_bit("t1_ce_idle", inst_ce, 1'b0);
        chk("t1_pc_idle", pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #4;
            chk("t1_pc", pc, 32'(i * 4));
            chk_bit("t1_valid", pc_valid, 1'b1);
        end

        // Memory wait states at pc=8
        do_reset();
        inst_ready = 1'b1;
        repeat (3) @(negedge clk);
        inst_ready = 1'b0;
        #4 chk("t2_pc_wait", pc, 32'h8);
        chk_bit("t2_ce_wait", inst_ce, 1'b1);
        chk_bit("t2_valid_wait", pc_valid, 1'b0);
        repeat (2) begin
            @(negedge clk); #4;
            chk("t2_pc_wait", pc, 32'h8);
        end
        @(negedge clk);
        inst_ready = 1'b1;
        #4 chk_bit("t2_valid_done", pc_valid, 1'b1);
        @(negedge clk); #4;
        chk("t2_pc_next", pc, 32'hC);

        // Pending redirect: branch during wait, then jump overwrites nothing lower
        do_reset();
        inst_ready = 1'b1;
        repeat (3) @(negedge clk);
        inst_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h43;
        #4 chk("t3_pc_wait", pc, 32'h8);
        @(negedge clk);
        branch_taken = 1'b0;
        @(negedge clk);
        inst_ready = 1'b1;
        #4 chk_bit("t3_valid_inflight", pc_valid, 1'b1);
        chk("t3_pc_inflight", pc, 32'h8);
        @(negedge clk);
        inst_ready = 1'b0; jump = 1'b1; jump_target = 32'h80;
        #4 chk("t3_pc_branch", pc, 32'h40);
        @(negedge clk);
        jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
        @(negedge clk);
        branch_taken = 1'b0; inst_ready = 1'b1;
        #4 chk_bit("t3_valid_40", pc_valid, 1'b1);
        @(negedge clk); #4;
        chk("t3_pc_jump_kept", pc, 32'h80);

        // Stall on completion at 0x10
        do_reset();
        inst_ready = 1'b1;
        repeat (5) @(negedge clk);
        stall = 1'b1;
        #4 chk("t4_pc_stall", pc, 32'h10);
        @(negedge clk); #4;
        chk_bit("t4_ce_hold1", inst_ce, 1'b0);
        chk("t4_pc_hold", pc, 32'h14);
        @(negedge clk);
        stall = 1'b0;
        #4 chk_bit("t4_ce_hold2", inst_ce, 1'b0);
        @(negedge clk); #4;
        chk_bit("t4_ce_resume", inst_ce, 1'b1);
        chk("t4_pc_resume", pc, 32'h14);

        // Exceptions in FETCH and HOLD, redirect in HOLD
        repeat (3) @(negedge clk);
        exc = 1'b1;
        #4 chk("t5_pc_exc", pc, 32'h20);
        chk_bit("t5_valid_exc", pc_valid, 1'b0);
        @(negedge clk);
        exc = 1'b0; stall = 1'b1;
        #4 chk("t5_pc_vec", pc, EXC_ADDR);
        @(negedge clk);
        exc = 1'b1;
        #4 chk("t5_pc_hold", pc, 32'h384);
        @(negedge clk);
        exc = 1'b0;
        #4 chk("t5_pc_vec_hold", pc, EXC_ADDR);
        chk_bit("t5_ce_vec_hold", inst_ce, 1'b1);
        @(negedge clk);
        jump = 1'b1; jump_target = 32'h500;
        @(negedge clk);
        jump = 1'b0; stall = 1'b0;
        #4 chk("t5_pc_hold_jump", pc, 32'h500);
        @(negedge clk); #4;
        chk_bit("t5_ce_after_hold", inst_ce, 1'b1);

        // Wrap-around and asynchronous reset mid-wait
        do_reset();
        inst_ready = 1'b1;
        @(negedge clk);
        jump = 1'b1; jump_target = 32'hFFFF_FFFE;
        @(negedge clk);
        jump = 1'b0;
        #4 chk("t6_pc_top", pc, 32'hFFFF_FFFC);
        chk("t6_plus4_wrap", pc_plus4, 32'h0);
        @(negedge clk); #4;
        chk("t6_pc_wrapped", pc, 32'h0);
        @(negedge clk);
        inst_ready = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        #1 chk("t6_pc_async", pc, 32'h0);
        chk_bit("t6_ce_async", inst_ce, 1'b0);
        chk_bit("t6_valid_async", pc_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; inst_ready = 1'b1;
        @(negedge clk); #4;
        chk_bit("t6_ce_restart", inst_ce, 1'b1);
        chk("t6_pc_restart", pc, 32'h0);

        @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
